robot_nav_ctrl: RTL

- Parametrised successor to the single-sensor robot controller.
- Fuses N_SENS distance channels, debounces the resulting distance class and runs a drive FSM (idle/forward/slow/stop/turn) that produces differential motor commands.
- Sits between the sensor front-end and the motor driver; all outputs are registered.

---
 rtl/robot_nav_ctrl.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/robot_nav_ctrl.sv
// rtl/robot_nav_ctrl.sv - multi-sensor drive controller: min fusion, class debounce, drive FSM, motor commands
// Optional watchdog fault enabled by defining ROBOT_NAV_WDOG_EN.
module robot_nav_ctrl #(
    parameter int N_SENS    = 3,
    parameter int DIST_W    = 16,
    parameter int STOP_TH   = 100,
    parameter int SLOW_TH   = 400,
    parameter int FILT_N    = 3,
    parameter int STOP_HOLD = 4,
    parameter int TURN_CYC  = 8,
    parameter int SPD_W     = 8,
`ifdef ROBOT_NAV_WDOG_EN
    parameter int WDOG_CYC  = 1024,
`endif
    parameter int SPD_MAX   = 200
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [N_SENS*DIST_W-1:0] dist_v,
    output logic [SPD_W-1:0]         mot_l,
    output logic [SPD_W-1:0]         mot_r,
    output logic                     dir_l,
    output logic                     dir_r,
    output logic [2:0]               state_o,
    output logic                     fault
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_FWD = 3'd1, S_SLOW = 3'd2, S_STOP = 3'd3, S_TURN = 3'd4, S_FAULT = 3'd5
    } state_t;
    typedef enum logic [1:0] {C_NEAR = 2'd0, C_MID = 2'd1, C_FAR = 2'd2} cls_t;

    localparam int CNT_MAX = (STOP_HOLD > TURN_CYC) ? STOP_HOLD : TURN_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int FILT_W  = $clog2(FILT_N + 1);
    localparam logic [DIST_W-1:0] STOP_TH_W = DIST_W'(STOP_TH);
    localparam logic [DIST_W-1:0] SLOW_TH_W = DIST_W'(SLOW_TH);
    localparam logic [SPD_W-1:0]  SPD_FULL  = SPD_W'(SPD_MAX);
    localparam logic [SPD_W-1:0]  SPD_HALF  = SPD_W'(SPD_MAX >> 1);

    logic [DIST_W-1:0] dmin_d, dmin_l_d, dmin_r_d, dmin_q, dmin_l_q, dmin_r_q;
    cls_t              raw_cls, prev_raw_q, filt_q, cls_eff;
    logic [FILT_W-1:0] streak_d, streak_q;
    state_t            state_d, state_q, follow_st;
    logic              turn_left_d, turn_left_q;
    logic [CNT_W-1:0]  cnt_d, cnt_q;
    logic [SPD_W-1:0]  mot_l_d, mot_r_d, mot_l_q, mot_r_q;
    logic              dir_l_d, dir_r_d, dir_l_q, dir_r_q;

    // The middle channel of an odd array only contributes to the overall minimum.
    always_comb begin
        dmin_d   = '1;
        dmin_l_d = '1;
        dmin_r_d = '1;
        for (int i = 0; i < N_SENS; i++) begin
            if (dist_v[i*DIST_W +: DIST_W] < dmin_d) dmin_d = dist_v[i*DIST_W +: DIST_W];
            if (i < N_SENS / 2 && dist_v[i*DIST_W +: DIST_W] < dmin_l_d)
                dmin_l_d = dist_v[i*DIST_W +: DIST_W];
            if (i >= (N_SENS + 1) / 2 && dist_v[i*DIST_W +: DIST_W] < dmin_r_d)
                dmin_r_d = dist_v[i*DIST_W +: DIST_W];
        end
    end

    always_comb begin
        raw_cls  = (dmin_q < STOP_TH_W) ? C_NEAR : (dmin_q < SLOW_TH_W) ? C_MID : C_FAR;
        streak_d = FILT_W'(1);
        if (raw_cls == prev_raw_q)
            streak_d = (streak_q < FILT_W'(FILT_N)) ? streak_q + FILT_W'(1) : streak_q;
        // NEAR bypasses the debounce so an obstacle stops the robot one cycle after sampling.
        cls_eff = (raw_cls == C_NEAR || streak_d >= FILT_W'(FILT_N)) ? raw_cls : filt_q;
        case (cls_eff)
            C_NEAR:  follow_st = S_STOP;
            C_MID:   follow_st = S_SLOW;
            default: follow_st = S_FWD;
        endcase
    end

`ifdef ROBOT_NAV_WDOG_EN
    localparam int WD_W = $clog2(WDOG_CYC + 1);
    logic [N_SENS*DIST_W-1:0] prev_dist_q;
    logic [WD_W-1:0]          wd_d, wd_q;
    logic                     wd_hit, fault_q;

    always_comb begin
        wd_hit = (wd_q == WD_W'(WDOG_CYC));
        wd_d   = '0;
        if (state_q != S_IDLE && state_q != S_FAULT && dist_v == prev_dist_q)
            wd_d = wd_hit ? wd_q : wd_q + WD_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_dist_q <= '0;
            wd_q        <= '0;
            fault_q     <= 1'b0;
        end else begin
            prev_dist_q <= dist_v;
            wd_q        <= wd_d;
            fault_q     <= (state_d == S_FAULT);
        end
    end
    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        turn_left_d = turn_left_q;
        if (!en) begin
            state_d = S_IDLE;
        end
`ifdef ROBOT_NAV_WDOG_EN
        else if (wd_hit && state_q != S_IDLE && state_q != S_FAULT) begin
            state_d = S_FAULT;
        end
`endif
        else begin
            case (state_q)
                S_IDLE, S_FWD, S_SLOW: state_d = follow_st;
                S_STOP: begin
                    if (cnt_q >= CNT_W'(STOP_HOLD - 1)) begin
                        state_d     = S_TURN;
                        turn_left_d = (dmin_l_q > dmin_r_q);
                    end
                end
                S_TURN: begin
                    if (cnt_q >= CNT_W'(TURN_CYC - 1)) state_d = follow_st;
                end
                default: state_d = state_q;
            endcase
        end
        cnt_d = '0;
        if (state_d == state_q) cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    end

    always_comb begin
        mot_l_d = '0;
        mot_r_d = '0;
        dir_l_d = 1'b1;
        dir_r_d = 1'b1;
        case (state_d)
            S_FWD:  begin mot_l_d = SPD_FULL; mot_r_d = SPD_FULL; end
            S_SLOW: begin mot_l_d = SPD_HALF; mot_r_d = SPD_HALF; end
            S_TURN: begin
                mot_l_d = SPD_HALF;
                mot_r_d = SPD_HALF;
                dir_l_d = ~turn_left_d;
                dir_r_d = turn_left_d;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dmin_q      <= '0;
            dmin_l_q    <= '0;
            dmin_r_q    <= '0;
            prev_raw_q  <= C_NEAR;
            streak_q    <= '0;
            filt_q      <= C_NEAR;
            state_q     <= S_IDLE;
            turn_left_q <= 1'b0;
            cnt_q       <= '0;
            mot_l_q     <= '0;
            mot_r_q     <= '0;
            dir_l_q     <= 1'b1;
            dir_r_q     <= 1'b1;
        end else begin
            dmin_q      <= dmin_d;
            dmin_l_q    <= dmin_l_d;
            dmin_r_q    <= dmin_r_d;
            prev_raw_q  <= raw_cls;
            streak_q    <= streak_d;
            filt_q      <= cls_eff;
            state_q     <= state_d;
            turn_left_q <= turn_left_d;
            cnt_q       <= cnt_d;
            mot_l_q     <= mot_l_d;
            mot_r_q     <= mot_r_d;
            dir_l_q     <= dir_l_d;
            dir_r_q     <= dir_r_d;
        end
    end

    assign state_o = state_q;
    assign mot_l   = mot_l_q;
    assign mot_r   = mot_r_q;
    assign dir_l   = dir_l_q;
    assign dir_r   = dir_r_q;
endmodule
